irq_sched: RTL and testbench

Interrupt scheduler for the single-cycle MIPS core. It collects level interrupt sources such as the timer flag, debounced push-buttons and trap, and latches rising edges as pending. It picks the highest-priority unmasked source and sequences entry into the handler through the main decoder's hold handshake and the CP0-side EXL/IV lines. It sits between the peripherals and `maindec`/CP0, and exposes a small memory-mapped register window on the same 5-bit address bus the timer uses.

---
 rtl/irq_sched.sv | 150 +++++++++++++++
 tb/tb_irq_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Interrupt scheduler: latches rising edges of level sources as pending, picks the
// highest-priority unmasked one and sequences handler entry via hold/holdACK and EXL/IV.
module irq_sched #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned wide = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [wide-1:0] wd,
  output logic [wide-1:0] rd,
  input  logic [31:0]     pc_current,
  input  logic            intctrl,
  input  logic            holdACK,
  input  logic            eret,
  output logic            hold,
  output logic            EXL,
  output logic            IV,
  output logic [31:0]     epc
);

  localparam logic [4:0] AddrMask  = 5'b11000;
  localparam logic [4:0] AddrPend  = 5'b11001;
  localparam logic [4:0] AddrEpc   = 5'b11010;
  localparam logic [4:0] AddrCause = 5'b11011;

  typedef enum logic [1:0] {StIdle, StReq, StTake, StService} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] irq_q, rise, pm;
  logic [NSRC-1:0] mask_q, mask_d, pend_q, pend_d;
  logic            iv_en_q, iv_en_d, iv_q, iv_d;
  logic            cause_valid_q, cause_valid_d;
  logic [2:0]      cause_idx_q, cause_idx_d;
  logic [2:0]      win, win_q, win_d;
  logic            any;
  logic [31:0]     epc_q, epc_d;

  assign rise = irq & ~irq_q;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    pm  = pend_q & mask_q;
    any = |pm;
    win = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pm[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    iv_en_d       = iv_en_q;
    pend_d        = pend_q;
    win_d         = win_q;
    epc_d         = epc_q;
    cause_valid_d = cause_valid_q;
    cause_idx_d   = cause_idx_q;
    iv_d          = iv_q;

    if (we && addr == AddrMask) begin
      mask_d  = wd[NSRC-1:0];
      iv_en_d = wd[31];
    end
    if (we && addr == AddrPend) pend_d = pend_d & ~wd[NSRC-1:0];

    unique case (state_q)
      StIdle: begin
        if (any) win_d = win;
        if (any && !intctrl) state_d = StReq;
      end
      StReq: begin
        if (any) win_d = win;
        if (holdACK) state_d = StTake;
      end
      StTake: begin
        epc_d         = pc_current;
        cause_valid_d = 1'b1;
        cause_idx_d   = win_q;
        iv_d          = iv_en_q;
        for (int i = 0; i < int'(NSRC); i++) begin
          if (win_q == 3'(i)) pend_d[i] = 1'b0;
        end
        state_d = StService;
      end
      StService: begin
        if (eret) begin
          cause_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh edge beats both W1C and the auto-ack.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      irq_q         <= '0;
      mask_q        <= '0;
      iv_en_q       <= 1'b0;
      pend_q        <= '0;
      win_q         <= '0;
      epc_q         <= '0;
      cause_valid_q <= 1'b0;
      cause_idx_q   <= '0;
      iv_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      irq_q         <= irq;
      mask_q        <= mask_d;
      iv_en_q       <= iv_en_d;
      pend_q        <= pend_d;
      win_q         <= win_d;
      epc_q         <= epc_d;
      cause_valid_q <= cause_valid_d;
      cause_idx_q   <= cause_idx_d;
      iv_q          <= iv_d;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      AddrMask: begin
        rd[NSRC-1:0] = mask_q;
        rd[31]       = iv_en_q;
      end
      AddrPend:  rd[NSRC-1:0] = pend_q;
      AddrEpc:   rd = wide'(epc_q);
      AddrCause: begin
        rd[31]  = cause_valid_q;
        rd[2:0] = cause_idx_q;
      end
      default: rd = '0;
    endcase
  end

  assign hold = (state_q == StReq);
  assign EXL  = (state_q == StService);
  assign IV   = iv_q;
  assign epc  = epc_q;

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios then random traffic, all checked against a
// behavioural model of pending set, priority choice and handler-entry phases.
module tb_irq_sched;

  localparam logic [4:0] AMASK  = 5'b11000;
  localparam logic [4:0] APEND  = 5'b11001;
  localparam logic [4:0] AEPC   = 5'b11010;
  localparam logic [4:0] ACAUSE = 5'b11011;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wd, rd, pc_current, epc;
  logic        intctrl, holdACK, eret, hold, EXL, IV;

  irq_sched #(.NSRC(4), .wide(32)) dut (
    .clk(clk), .rst(rst), .irq(irq), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .pc_current(pc_current), .intctrl(intctrl), .holdACK(holdACK), .eret(eret),
    .hold(hold), .EXL(EXL), .IV(IV), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef enum int {MIdle, MReq, MTake, MSvc} mphase_e;

  mphase_e     m_ph;
  logic [3:0]  m_irqq, m_pend, m_mask;
  bit          m_iven, m_cval, m_iv;
  int          m_win, m_cidx;
  logic [31:0] m_epc;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Index of the lowest set bit, via isolating it arithmetically.
  function automatic int lowest(input logic [3:0] x);
    logic [3:0] iso;
    iso = x & (~x + 4'd1);
    return $clog2(iso);
  endfunction

  task automatic model_reset();
    m_ph = MIdle; m_irqq = '0; m_pend = '0; m_mask = '0; m_iven = 0;
    m_cval = 0; m_iv = 0; m_win = 0; m_cidx = 0; m_epc = '0;
  endtask

  task automatic model_step();
    logic [3:0] rise, pm, pend_n;
    bit any;
    int w;
    rise   = irq & ~m_irqq;
    pm     = m_pend & m_mask;
    any    = (pm != 0);
    w      = any ? lowest(pm) : 0;
    pend_n = m_pend;
    if (we && addr == APEND) pend_n &= ~wd[3:0];
    if (m_ph == MTake) pend_n &= ~(4'd1 << m_win);
    pend_n |= rise;
    case (m_ph)
      MIdle: begin
        if (any) m_win = w;
        if (any && !intctrl) m_ph = MReq;
      end
      MReq: begin
        if (any) m_win = w;
        if (holdACK) m_ph = MTake;
      end
      MTake: begin
        m_epc = pc_current; m_cval = 1; m_cidx = m_win; m_iv = m_iven; m_ph = MSvc;
      end
      MSvc: if (eret) begin m_cval = 0; m_ph = MIdle; end
      default: m_ph = MIdle;
    endcase
    if (we && addr == AMASK) begin m_mask = wd[3:0]; m_iven = wd[31]; end
    m_pend = pend_n;
    m_irqq = irq;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] val);
    addr = a;
    #1 val = rd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("hold", hold, 32'(m_ph == MReq));
    chk("EXL", EXL, 32'(m_ph == MSvc));
    chk("IV", IV, 32'(m_iv));
    chk("epc", epc, m_epc);
    rd_reg(APEND, v);  chk("PEND", v, {28'b0, m_pend});
    rd_reg(ACAUSE, v); chk("CAUSE", v, {m_cval, 28'b0, 3'(m_cidx)});
    rd_reg(AMASK, v);  chk("MASK", v, {m_iven, 27'b0, m_mask});
    rd_reg(AEPC, v);   chk("EPCreg", v, m_epc);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
  endtask

  initial begin
    // Reset values
    rst = 1'b0; irq = 4'hF; we = 0; addr = '0; wd = '0; pc_current = '0;
    intctrl = 0; holdACK = 0; eret = 0;
    model_reset();
    #20;
    chk("rst_hold", hold, 32'd0);
    chk("rst_EXL", EXL, 32'd0);
    rd_reg(APEND, v); chk("rst_PEND", v, 32'd0);
    irq = 4'h0;
    @(negedge clk); rst = 1'b1;
    tick(); tick();
    rd_reg(APEND, v); chk("post_rst_PEND", v, 32'd0);

    // Basic entry and return
    wr(AMASK, 32'h1);
    pc_current = 32'h40; irq = 4'b0001;
    tick();
    chk("basic_hold_p1", hold, 32'd0);
    tick();
    chk("basic_hold_p2", hold, 32'd1);
    holdACK = 1; tick(); holdACK = 0;
    chk("basic_take_hold", hold, 32'd0);
    tick();
    chk("basic_EXL", EXL, 32'd1);
    rd_reg(AEPC, v);   chk("basic_EPC", v, 32'h40);
    rd_reg(ACAUSE, v); chk("basic_CAUSE", v, 32'h8000_0000);
    rd_reg(APEND, v);  chk("basic_PEND0", v & 32'h1, 32'd0);
    eret = 1; tick(); eret = 0;
    chk("basic_eret_EXL", EXL, 32'd0);
    irq = 4'b0000; tick();

    // Priority and masking
    wr(AMASK, 32'hC);
    irq = 4'b1010;
    tick(); tick();
    holdACK = 1; tick(); holdACK = 0;
    tick();
    rd_reg(ACAUSE, v); chk("prio_CAUSE", v, 32'h8000_0003);
    rd_reg(APEND, v);  chk("prio_PEND", v, 32'h2);
    eret = 1; tick(); eret = 0;
    irq = 4'b0000; tick(); tick();
    chk("prio_masked_idle", hold, 32'd0);

    // Branch deferral
    wr(AMASK, 32'h1);
    intctrl = 1; irq = 4'b0001;
    tick(); tick(); tick();
    chk("defer_hold_low", hold, 32'd0);
    intctrl = 0; tick();
    chk("defer_hold_rise", hold, 32'd1);
    holdACK = 1; tick(); holdACK = 0;
    tick();

    // Nesting blocked, then re-entry for source 2
    wr(AMASK, 32'h8000_0005);
    irq = 4'b0101;
    tick(); tick(); tick();
    chk("nest_EXL", EXL, 32'd1);
    chk("nest_hold", hold, 32'd0);
    eret = 1; tick(); eret = 0;
    chk("nest_eret_EXL", EXL, 32'd0);
    tick();
    chk("nest_reentry_hold", hold, 32'd1);
    pc_current = 32'h1234; holdACK = 1; tick(); holdACK = 0;
    tick();
    rd_reg(ACAUSE, v); chk("nest_CAUSE", v, 32'h8000_0002);
    chk("nest_IV", IV, 32'd1);
    // W1C racing a fresh edge on the same bit
    irq = 4'b0001; tick();
    irq = 4'b0101; wr(APEND, 32'h4);
    rd_reg(APEND, v); chk("race_PEND2", (v >> 2) & 32'h1, 32'd1);
    wr(APEND, 32'hF);
    eret = 1; tick(); eret = 0;
    tick(); tick();

    // Asynchronous reset mid-REQ
    irq = 4'b0000; tick();
    irq = 4'b0001; tick(); tick();
    chk("areset_pre_hold", hold, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("areset_hold", hold, 32'd0);
    chk("areset_EXL", EXL, 32'd0);
    model_reset();
    irq = 4'b0000;
    @(negedge clk); rst = 1'b1;
    wr(AMASK, 32'hF);
    tick(); tick();
    chk("areset_no_take", hold, 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      irq        = 4'($urandom_range(0, 15));
      intctrl    = ($urandom_range(0, 3) == 0);
      holdACK    = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 3) == 0);
      pc_current = $urandom;
      case ($urandom_range(0, 7))
        0: wr(AMASK, {1'($urandom_range(0, 1)), 27'b0, 4'($urandom_range(0, 15))});
        1: wr(APEND, 32'($urandom_range(0, 15)));
        default: begin addr = 5'($urandom_range(0, 31)); tick(); end
      endcase
    end
    holdACK = 0; eret = 0; intctrl = 0;
    rd_reg(5'b00011, v); chk("unmapped_rd", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
